// File: rtl/serial_tx_en.sv
// Parallel-in, serial-out transmitter feeding an enabled-DFF / shift-register receiver.
// Latency: word accepted at edge k, bits on o_d in cycles k+1..k+WIDTH (plus hold cycles), o_done at k+WIDTH+1.
// Backpressure: o_ready only in IDLE (i_valid ignored otherwise); i_hold freezes shifting and drops o_en.
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   reset     synchronous, active-high reset
//   i_valid   parallel word available on i_data
//   i_data    WIDTH-bit word to transmit
//   o_ready   block can accept a word this cycle (IDLE)
//   i_hold    stall request, freezes shifting while high
//   o_en      serial bit strobe, receiver captures o_d when high
//   o_d       current serial data bit
//   o_busy    transfer in progress (SHIFT or DONE)
//   o_done    one-cycle pulse after the last bit
module serial_tx_en #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_ready,
   input  logic             i_hold,
   output logic             o_en,
   output logic             o_d,
   output logic             o_busy,
   output logic             o_done
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_shreg;
   logic [WIDTH-1:0] w_shreg_nxt;
   logic [WIDTH-1:0] w_shreg_shifted;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;

   // Shift toward the transmitting end, zero-filling the vacated bit.
   assign w_shreg_shifted = (MSB_FIRST != 0) ? {r_shreg[WIDTH-2:0], 1'b0}
                                             : {1'b0, r_shreg[WIDTH-1:1]};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_shreg <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_shreg <= w_shreg_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_shreg_nxt = r_shreg;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (i_valid) begin
               w_shreg_nxt = i_data;
               w_cnt_nxt   = '0;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // A held cycle leaves everything frozen; the bit stays on o_d.
            if (!i_hold) begin
               w_shreg_nxt = w_shreg_shifted;
               if (r_cnt == LAST) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_DONE;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign o_ready = (r_state == S_IDLE);
   assign o_busy  = (r_state != S_IDLE);
   assign o_done  = (r_state == S_DONE);
   // Only combinational input-to-output path: the hold must kill the strobe in the same cycle.
   assign o_en    = (r_state == S_SHIFT) && !i_hold;
   assign o_d     = (MSB_FIRST != 0) ? r_shreg[WIDTH-1] : r_shreg[0];

endmodule

// File: tb/tb_serial_tx_en.sv
module tb_serial_tx_en;

   logic       clk = 1'b0;
   logic       rst;
   // 8-bit MSB-first instance
   logic       v8, h8, r8, en8, od8, busy8, done8;
   logic [7:0] d8;
   // 4-bit LSB-first instance
   logic       v4, h4, r4, en4, od4, busy4, done4;
   logic [3:0] d4;

   int errors = 0;
   int checks = 0;

   // Enabled serial-in receiver used for loopback.
   logic [7:0] rx;
   int         rxn;

   always #5 clk = ~clk;

   serial_tx_en #(.WIDTH(8), .MSB_FIRST(1)) u8 (
      .clk(clk), .reset(rst), .i_valid(v8), .i_data(d8), .o_ready(r8),
      .i_hold(h8), .o_en(en8), .o_d(od8), .o_busy(busy8), .o_done(done8));

   serial_tx_en #(.WIDTH(4), .MSB_FIRST(0)) u4 (
      .clk(clk), .reset(rst), .i_valid(v4), .i_data(d4), .o_ready(r4),
      .i_hold(h4), .o_en(en4), .o_d(od4), .o_busy(busy4), .o_done(done4));

   always @(posedge clk) begin
      if (rst) begin
         rx  <= 8'h00;
         rxn <= 0;
      end else if (v8 && r8) begin
         rxn <= 0;
      end else if (en8) begin
         rx  <= {rx[6:0], od8};
         rxn <= rxn + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: i-th transmitted bit of a word, straight from the bit ordering rule.
   function automatic logic msb_bit(input logic [7:0] w, input int i);
      return w[7-i];
   endfunction

   function automatic logic lsb_bit(input logic [3:0] w, input int i);
      return w[i];
   endfunction

   // Send one word on the 8-bit instance. Hold is asserted for hold_len cycles once
   // hold_at bits have been strobed; i_valid with 0x00 is driven in cycles rej_lo..rej_hi
   // after acceptance. exp_done is the expected o_done cycle relative to acceptance.
   task automatic xfer8(input logic [7:0] w, input int hold_at, input int hold_len,
                        input int rej_lo, input int rej_hi, input int exp_done);
      int bits;
      int hc;
      bit got_done;
      bits = 0;
      hc = 0;
      got_done = 0;
      chk("ready_before_send", r8, 1);
      v8 = 1'b1;
      d8 = w;
      tick();
      v8 = 1'b0;
      d8 = 8'($urandom);
      for (int c = 1; c <= 40 && !got_done; c++) begin
         h8 = (bits == hold_at && hc < hold_len);
         if (h8) hc++;
         if (c >= rej_lo && c <= rej_hi) begin
            v8 = 1'b1;
            d8 = 8'h00;
         end else begin
            v8 = 1'b0;
         end
         #1;
         if (h8) begin
            chk("hold_en_low", en8, 0);
            chk("hold_d_stable", od8, msb_bit(w, bits));
         end else if (en8) begin
            if (bits < 8) chk("bit", od8, msb_bit(w, bits));
            else chk("extra_en", 1, 0);
            bits++;
         end
         if (done8) begin
            got_done = 1;
            chk("done_cycle", c, exp_done);
            chk("en_count", bits, 8);
         end
         tick();
      end
      h8 = 1'b0;
      v8 = 1'b0;
      chk("done_seen", got_done, 1);
      #1;
      chk("ready_after_done", r8, 1);
      chk("idle_after_done", busy8, 0);
   endtask

   initial begin
      bit seen;
      int bits;
      int c;
      logic [7:0] w;
      logic [3:0] w4;
      rst = 1'b1;
      v8 = 0; h8 = 0; d8 = 0;
      v4 = 0; h4 = 0; d4 = 0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_ready", r8, 1);
      chk("rst_en", en8, 0);
      chk("rst_d", od8, 0);
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_ready4", r4, 1);

      // Hold while idle has no effect.
      h8 = 1'b1;
      tick();
      tick();
      chk("idle_hold_ready", r8, 1);
      chk("idle_hold_en", en8, 0);
      h8 = 1'b0;

      // Basic MSB-first transfer.
      xfer8(8'hA5, -1, 0, -1, -1, 9);
      // Stall of 3 cycles after the 4th bit.
      xfer8(8'hC3, 4, 3, -1, -1, 12);
      // Busy rejection: i_valid with 0x00 from accept+2 to accept+5.
      xfer8(8'hFF, -1, 0, 2, 5, 9);
      tick();
      chk("no_second_xfer", busy8, 0);
      // Hold on the final bit delays DONE.
      xfer8(8'h81, 7, 2, -1, -1, 11);

      // Reset during the 4th bit.
      v8 = 1'b1;
      d8 = 8'h5A;
      tick();
      v8 = 1'b0;
      bits = 0;
      c = 0;
      while (bits < 3 && c < 20) begin
         if (en8) bits++;
         tick();
         c++;
      end
      chk("midrst_reached_bit4", en8 && (od8 == msb_bit(8'h5A, 3)), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_en", en8, 0);
      chk("midrst_busy", busy8, 0);
      chk("midrst_ready", r8, 1);
      chk("midrst_d", od8, 0);
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (done8 || en8) seen = 1;
         tick();
      end
      chk("midrst_no_done", seen, 0);

      // Simultaneous reset and valid: reset wins.
      rst = 1'b1;
      v8 = 1'b1;
      d8 = 8'h77;
      tick();
      rst = 1'b0;
      v8 = 1'b0;
      chk("rstvalid_busy", busy8, 0);
      tick();
      chk("rstvalid_still_idle", busy8, 0);

      // LSB-first, WIDTH=4: directed 0001 then random words.
      for (int k = 0; k < 4; k++) begin
         bit got;
         w4 = (k == 0) ? 4'b0001 : 4'($urandom);
         chk("lsb_ready", r4, 1);
         v4 = 1'b1;
         d4 = w4;
         tick();
         v4 = 1'b0;
         d4 = 4'($urandom);
         bits = 0;
         got = 0;
         for (int cc = 1; cc <= 20 && !got; cc++) begin
            #1;
            if (en4) begin
               if (bits < 4) chk("lsb_bit", od4, lsb_bit(w4, bits));
               else chk("lsb_extra_en", 1, 0);
               bits++;
            end
            if (done4) begin
               got = 1;
               chk("lsb_done_cycle", cc, 5);
               chk("lsb_en_count", bits, 4);
            end
            tick();
         end
         chk("lsb_done_seen", got, 1);
      end

      // Loopback: 16 random words back-to-back into the serial receiver.
      for (int k = 0; k < 16; k++) begin
         bit got;
         c = 0;
         while (!r8 && c < 20) begin
            tick();
            c++;
         end
         chk("lb_ready", r8, 1);
         w = 8'($urandom);
         v8 = 1'b1;
         d8 = w;
         tick();
         v8 = 1'b0;
         got = 0;
         for (int cc = 0; cc < 30 && !got; cc++) begin
            if (done8) got = 1;
            else tick();
         end
         chk("lb_done_seen", got, 1);
         chk("lb_word", rx, w);
         chk("lb_en_count", rxn, 8);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
